// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO with per-bit direction, synchronised input readback, set/clear and edge IRQs.
// Latency: writes take effect at the sampling negedge; read data valid after the sampling negedge; pin-to-irq 4 negedges.
// Backpressure: none, no wait states; en is a single-cycle strobe per access. Optional IRQ block: `GPIO_IRQ_EN.
module gpio_port #(
    parameter int WIDTH = 32,
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    // Register map
    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IEN  = 3'd3;
    localparam logic [2:0] A_PEND = 3'd4;
    localparam logic [2:0] A_EDGE = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_rdata;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_rd_mux;
    logic [WIDTH-1:0] w_ien_rd;
    logic [WIDTH-1:0] w_pend_rd;
    logic [WIDTH-1:0] w_edge_rd;

    assign w_wr = en & we;
    assign w_rd = en & ~we;

    // Output and direction registers; SET/CLR give read-modify-write-free bit updates
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_dir <= '0;
        end else if (w_wr) begin
            case (addr)
                A_OUT:   r_out <= wdata;
                A_DIR:   r_dir <= wdata;
                A_SET:   r_out <= r_out | wdata;
                A_CLR:   r_out <= r_out & ~wdata;
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous pins; s2 is the architectural IN value
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= gpio_in;
            r_s2 <= r_s1;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_edge;
    logic             r_irq;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr_mask;

    // Per-bit edge detect: EDGE=0 picks rising, EDGE=1 picks falling
    always_comb begin
        w_event = (r_s2 & ~r_s3 & ~r_edge) | (~r_s2 & r_s3 & r_edge);
    end

    assign w_clr_mask = (w_wr && (addr == A_PEND)) ? wdata : '0;

    // Third stage holds the previous synchronised value for edge comparison
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_s3 <= '0;
        end else begin
            r_s3 <= r_s2;
        end
    end

    // Interrupt enable and edge-select registers
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_ien  <= '0;
            r_edge <= '0;
        end else if (w_wr) begin
            case (addr)
                A_IEN:   r_ien  <= wdata;
                A_EDGE:  r_edge <= wdata;
                default: ;
            endcase
        end
    end

    // Pending bits: W1C, a new event on the same bit in the same cycle survives the clear
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | (w_event & r_ien);
        end
    end

    // Registered interrupt; IEN masks without discarding pending state
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_pend & r_ien);
        end
    end

    assign irq       = r_irq;
    assign w_ien_rd  = r_ien;
    assign w_pend_rd = r_pend;
    assign w_edge_rd = r_edge;
`else
    assign irq       = 1'b0;
    assign w_ien_rd  = '0;
    assign w_pend_rd = '0;
    assign w_edge_rd = '0;
`endif

    // Read-data select; SET and CLR addresses alias OUT on reads
    always_comb begin
        w_rd_mux = '0;
        case (addr)
            A_OUT:   w_rd_mux = r_out;
            A_DIR:   w_rd_mux = r_dir;
            A_IN:    w_rd_mux = r_s2;
            A_IEN:   w_rd_mux = w_ien_rd;
            A_PEND:  w_rd_mux = w_pend_rd;
            A_EDGE:  w_rd_mux = w_edge_rd;
            A_SET:   w_rd_mux = r_out;
            A_CLR:   w_rd_mux = r_out;
            default: w_rd_mux = '0;
        endcase
    end

    // Read data register only loads on a read strobe and holds otherwise
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign rdata    = r_rdata;
    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign led      = ~r_out[LED_W-1:0];

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed and random register/pin traffic against a transaction-level model of the GPIO port.
// Latency: checks every output 1 time unit after each active (falling) edge.
// Backpressure: none; the bench issues one access per cycle.
module tb_gpio_port;
    localparam int WIDTH = 32;
    localparam int LED_W = 8;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             we;
    logic [2:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic [LED_W-1:0] led;
    logic             irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_port #(.WIDTH(WIDTH), .LED_W(LED_W)) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .led(led), .irq(irq)
    );

    // Reference model: architectural registers plus a history of pin samples
    logic [31:0] m_out, m_dir, m_ien, m_pend, m_edge, m_rdata;
    logic        m_irq;
    logic [31:0] m_hist [3];   // m_hist[0] = pins seen at the most recent edge

    task automatic m_reset();
        m_out = '0; m_dir = '0; m_ien = '0; m_pend = '0; m_edge = '0;
        m_rdata = '0; m_irq = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd6, 3'd7: return m_out;
            3'd1: return m_dir;
            3'd2: return m_hist[1];        // pins as they were two edges back
            3'd3: return m_ien;
            3'd4: return m_pend;
            default: return m_edge;
        endcase
    endfunction

    // Advance the model by one falling edge using the inputs currently driven
    task automatic m_edge_step();
        logic [31:0] now_v, old_v, ev, clr, nxt_pend;
        logic        nxt_irq;
        now_v    = m_hist[1];
        old_v    = m_hist[2];
        ev       = (now_v & ~old_v & ~m_edge) | (~now_v & old_v & m_edge);
        clr      = (en && we && addr == 3'd4) ? wdata : 32'h0;
        nxt_pend = (m_pend & ~clr) | (ev & m_ien);
        nxt_irq  = |(m_pend & m_ien);
        if (en && !we) m_rdata = m_read(addr);
        if (en && we) begin
            case (addr)
                3'd0: m_out = wdata;
                3'd1: m_dir = wdata;
                3'd3: if (IRQ) m_ien = wdata;
                3'd5: if (IRQ) m_edge = wdata;
                3'd6: m_out = m_out | wdata;
                3'd7: m_out = m_out & ~wdata;
                default: ;
            endcase
        end
        m_pend    = nxt_pend;
        m_irq     = nxt_irq;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = gpio_in;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_oe", gpio_oe, m_dir);
        chk("led", {24'h0, led}, {24'h0, ~m_out[7:0]});
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
        chk("rdata", rdata, m_rdata);
    endtask

    // One bus cycle: drive after the rising edge, let the falling edge sample, then compare
    task automatic step(input logic e, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [31:0] gin);
        @(posedge clk);
        en = e; we = w; addr = a; wdata = d; gpio_in = gin;
        @(negedge clk);
        m_edge_step();
        #1;
        chk_all();
    endtask

    initial begin
        logic [31:0] g;
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("por_gpio_out", gpio_out, 32'h0);
        chk("por_gpio_oe", gpio_oe, 32'h0);
        chk("por_led", {24'h0, led}, 32'hFF);
        chk("por_irq", {31'h0, irq}, 32'h0);
        chk("por_rdata", rdata, 32'h0);
        @(posedge clk);
        rst = 1'b0;

        // Mid-run asynchronous reset with OUT all ones
        step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0);
        chk("out_ones", gpio_out, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 3'd1, 32'h0000_FFFF, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gpio_out", gpio_out, 32'h0);
        chk("arst_gpio_oe", gpio_oe, 32'h0);
        chk("arst_led", {24'h0, led}, 32'hFF);
        chk("arst_irq", {31'h0, irq}, 32'h0);
        m_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 3'(k), 32'h0, 32'h0);
            chk("rd_after_rst", rdata, 32'h0);
        end

        // Plain and atomic writes
        step(1'b1, 1'b1, 3'd0, 32'h0000_00A5, 32'h0);
        chk("led_a5", {24'h0, led}, 32'h5A);
        step(1'b1, 1'b1, 3'd6, 32'h0000_0100, 32'h0);
        chk("set_out", gpio_out, 32'h0000_01A5);
        step(1'b1, 1'b1, 3'd7, 32'h0000_0005, 32'h0);
        chk("clr_out", gpio_out, 32'h0000_01A0);
        step(1'b1, 1'b0, 3'd6, 32'h0, 32'h0);
        chk("rd_set_alias", rdata, 32'h0000_01A0);

        // Input synchroniser latency: pins sampled at edge N
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h1234_5678);
        step(1'b1, 1'b0, 3'd2, 32'h0, 32'h1234_5678);
        chk("in_early_old", rdata, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h1234_5678);
        step(1'b1, 1'b0, 3'd2, 32'h0, 32'h1234_5678);
        chk("in_sync", rdata, 32'h1234_5678);

`ifdef GPIO_IRQ_EN
        // Rising interrupt on bit 0
        step(1'b1, 1'b1, 3'd3, 32'h1, 32'h0);
        step(1'b1, 1'b1, 3'd5, 32'h0, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h1);     // N
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h1);     // N+1
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h1);     // N+2: PEND set
        chk("irq_not_yet", {31'h0, irq}, 32'h0);
        step(1'b1, 1'b0, 3'd4, 32'h0, 32'h1);     // N+3
        chk("pend_rise", rdata, 32'h1);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        step(1'b1, 1'b1, 3'd4, 32'h1, 32'h1);     // W1C
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h1);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Falling edge on a masked bit is discarded
        step(1'b1, 1'b1, 3'd5, 32'h8, 32'h8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
        chk("pend_masked", rdata, 32'h0);

        // Enable bit 3 and retrigger
        step(1'b1, 1'b1, 3'd3, 32'h8, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
        chk("pend_fall", rdata, 32'h8);

        // Clear in the same cycle as a new event: the event wins
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h8);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);     // N
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);     // N+1
        step(1'b1, 1'b1, 3'd4, 32'h8, 32'h0);     // N+2: clear + set
        step(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
        chk("pend_collide", rdata, 32'h8);
        chk("irq_collide", {31'h0, irq}, 32'h1);

        // Masking with IEN keeps PEND; re-enabling raises irq again
        step(1'b1, 1'b1, 3'd3, 32'h0, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        step(1'b1, 1'b1, 3'd3, 32'h8, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("irq_reenabled", {31'h0, irq}, 32'h1);
`else
        // Without the interrupt block IEN writes are ignored and irq stays low
        step(1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0);
        step(1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 3'd0, 32'h0, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
            chk("irq_off", {31'h0, irq}, 32'h0);
        end
        for (int k = 3; k < 6; k++) begin
            step(1'b1, 1'b0, 3'(k), 32'h0, 32'h0);
            chk("rd_off", rdata, 32'h0);
        end
`endif

        // Random traffic against the model
        g = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) g = $urandom;
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                 $urandom, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O port on the CPU peripheral bus, successor to the fixed 32-bit output-only port. Adds per-bit direction, synchronised input readback, atomic set/clear writes and per-bit edge-triggered interrupts with write-1-to-clear pending bits. It keeps the active-low LED mirror of the low output bits. It sits on the peripheral address decoder next to the other memory-mapped I/O blocks.

## Interface
- WIDTH, 32: number of GPIO bits and the bus data width.
- LED_W, 8: number of low output bits mirrored to the LEDs; must be ≤ WIDTH.
- clk  in  1: system clock. All state updates on the falling edge.
- rst  in  1: reset, asynchronous, active-high.
- en  in  1: block select from the address decoder.
- we  in  1: write strobe; qualified by en.
- addr  in  3: register select.
- wdata  in  WIDTH: write data.
- rdata  out  WIDTH: registered read data.
- gpio_in  in  WIDTH: raw pin inputs; asynchronous to clk.
- gpio_out  out  WIDTH: output register OUT.
- gpio_oe  out  WIDTH: direction register DIR; 1 = drive.
- led  out  LED_W: ~OUT[LED_W-1:0], for active-low LEDs.
- irq  out  1: |(PEND & IEN), registered.

## Operation
- Register map (addr):
  - 0 OUT: read/write.
  - 1 DIR: read/write.
  - 2 IN: read-only; synchronised pins, all bits, regardless of DIR.
  - 3 IEN: read/write.
  - 4 PEND: read; write-1-to-clear.
  - 5 EDGE: read/write; 0 = rising, 1 = falling per bit.
  - 6 SET: OUT |= wdata; reads return OUT.
  - 7 CLR: OUT &= ~wdata; reads return OUT.
- Write to addr 2 is ignored.
- Write: on a negedge with en & we, the addressed register is updated.
- Read: on a negedge with en & ~we, rdata is loaded from the addressed register. rdata holds its value otherwise, including during writes.
- Input path: three flops per bit, s1 <= gpio_in, s2 <= s1, s3 <= s2. IN reads s2.
  - Rising event: s2 & ~s3.
  - Falling event: ~s2 & s3.
  - The event type is selected per bit by EDGE.
- Pending update at every negedge: PEND <= (PEND & ~clr_mask) | (event & IEN).
  - clr_mask is wdata on a write to addr 4, else 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Clearing IEN does not clear PEND. It does mask irq.
- Re-enabling IEN with PEND still set raises irq again.
- Events on bits with IEN = 0 are discarded and are not latched.

## Timing
- Reset values: OUT, DIR, IEN, PEND, EDGE, s1, s2, s3, rdata, irq all 0. gpio_out = 0, gpio_oe = 0, led = all ones.
- Reset is asynchronous: asserting it mid-operation clears all state immediately. Behaviour resumes at the first negedge after release.
- Write latency: gpio_out, gpio_oe and led change at the same negedge that samples the write.
- Read latency: rdata is valid after the sampling negedge, one cycle after the request.
- Read of IN reflects a pin change made before negedge N at negedge N+2, with rdata valid after N+3 if the read is issued then.
- Interrupt latency: pin change before negedge N, event visible combinationally after N+1, PEND set at N+2, irq high after N+3.
- Input pulses shorter than one clk period may be missed. Pulses of two or more periods are guaranteed to be captured.
- Pins held high through reset release produce a rising event 2 negedges later. No PEND is set, because IEN = 0.
- There is no wait state; en is assumed to be a single-cycle strobe per access.

## Configuration
- GPIO_IRQ_EN defined: IEN, PEND and EDGE registers, the s3 stage and irq are implemented as above.
- GPIO_IRQ_EN undefined:
  - addr 3, 4 and 5 read 0 and writes to them are ignored.
  - irq is tied 0.
  - s3 and the edge logic are removed.
  - OUT, DIR, IN, SET, CLR and led are unchanged.

## Test plan
- Reset: assert rst mid-run with OUT = 0xFFFFFFFF.
  - Expect gpio_out = 0, gpio_oe = 0, led = 8'hFF, irq = 0 immediately.
  - Then read all 8 addresses: expect 0.
- Write/atomic:
  - Write OUT = 0x000000A5: expect led = 8'h5A at the same negedge.
  - SET 0x00000100: expect OUT = 0x000001A5.
  - CLR 0x00000005: expect OUT = 0x000001A0.
  - Read addr 6: expect rdata = 0x000001A0.
- Input sync: drive gpio_in = 0x12345678 before negedge N, then read IN at N+2. Expect rdata = 0x12345678 after N+3; a read at N+1 still shows the old value.
- Rising IRQ: IEN = 0x1, EDGE = 0, raise gpio_in[0] before N.
  - Expect PEND = 0x1 at N+2 and irq = 1 after N+3.
  - Write 1 to addr 4: expect irq = 0 one cycle later.
- Falling/mask and collision:
  - EDGE[3] = 1, IEN[3] = 0, drop gpio_in[3]: expect PEND = 0.
  - Set IEN[3] = 1 and retrigger.
  - Issue the W1C in the same cycle as a new event: expect PEND[3] to remain 1.
- Macro off (GPIO_IRQ_EN undefined): toggle all inputs with IEN writes of 0xFFFFFFFF. Expect irq = 0 throughout and reads of addr 3–5 = 0.
